iterative_subtractor: RTL and testbench

- Multi-cycle two's-complement subtractor computing a - b, CHUNK bits per cycle, as a + ~b + 1 with the carry held in a register between chunks.
- Inverse-operation companion to the ALU combinational adder chain.
- Trades latency for area in the ALU datapath.
- Uses valid/ready handshakes on input and output.
- Reports unsigned borrow, signed overflow, zero and negative flags.

---
 rtl/iterative_subtractor_if.sv | 28 ++
 rtl/iterative_subtractor.sv | 149 ++++++++++++++
 tb/tb_iterative_subtractor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_subtractor_if.sv
// rtl/iterative_subtractor_if.sv - operand/result handshake bundle for the iterative subtractor
interface iterative_subtractor_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;
    logic             neg;

    // Producer of operands and consumer of results
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero, neg
    );

    // The subtractor itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero, neg
    );
endinterface

// File: rtl/iterative_subtractor.sv
// rtl/iterative_subtractor.sv - multi-cycle a - b, CHUNK bits per cycle via a + ~b + 1
module iterative_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iterative_subtractor_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int MSB   = WIDTH - 1;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] res_upd;

    // One chunk adder: select slice cnt_q, add with inverted subtrahend and carry-in,
    // and form the working result with that slice replaced.
    always_comb begin
        a_c     = '0;
        b_c     = '0;
        res_upd = res_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_c = a_q[k*CHUNK +: CHUNK];
                b_c = b_q[k*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, a_c} + {1'b0, ~b_c} + {{CHUNK{1'b0}}, carry_q};
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                res_upd[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
    end

    // Next-state logic for the IDLE -> CALC (N cycles) -> DONE sequence
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                res_d   = res_upd;
                carry_d = sum[CHUNK];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Flags use the latched operands and the completed working value
                    diff_d   = res_upd;
                    borrow_d = ~sum[CHUNK];
                    ovf_d    = (a_q[MSB] != b_q[MSB]) && (res_upd[MSB] != a_q[MSB]);
                    zero_d   = ~|res_upd;
                    neg_d    = res_upd[MSB];
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Handshake outputs are registered so in_ready stays low until the first edge after reset
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
endmodule

// File: tb/tb_iterative_subtractor.sv
// tb/tb_iterative_subtractor.sv - scoreboard bench for iterative_subtractor
module tb_iterative_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_hs = -100;

    typedef struct {
        logic [63:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
        logic        neg;
        int          accept;
        int          stall;
    } exp_t;

    exp_t sb[$];

    iterative_subtractor_if #(.WIDTH(64)) bus ();

    iterative_subtractor #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular and signed arithmetic
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input int stall, input int acc);
        exp_t e;
        logic signed [64:0] full;
        full     = $signed({a[63], a}) - $signed({b[63], b});
        e.diff   = a - b;
        e.borrow = (a < b);
        e.ovf    = full[64] ^ full[63];
        e.zero   = (e.diff == 64'd0);
        e.neg    = e.diff[63];
        e.accept = acc;
        e.stall  = stall;
        return e;
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b, input int stall,
                        input bit scored, output int acc);
        int n;
        @(negedge clk);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready never rose");
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (scored) sb.push_back(model(a, b, stall, acc));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
        end
    endtask

    // Monitor: pops the expected result whenever the DUT presents one
    initial begin
        bit          was_valid;
        bit          post_hs;
        int          stall_left;
        logic [63:0] last_diff;
        exp_t        e;
        was_valid  = 1'b0;
        post_hs    = 1'b0;
        stall_left = 0;
        last_diff  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                was_valid = 1'b0;
                post_hs   = 1'b0;
                continue;
            end
            if (post_hs) begin
                chk("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
                chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
                chk("post_hs_diff_held", bus.diff, last_diff);
                post_hs = 1'b0;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: diff %h with no pending operation", bus.diff);
                    bus.out_ready = 1'b1;
                end else begin
                    e = sb[0];
                    if (!was_valid) begin
                        chk("latency", 64'(cyc - e.accept), 64'd4);
                        stall_left = e.stall;
                    end
                    chk("diff", bus.diff, e.diff);
                    chk("borrow", 64'(bus.borrow), 64'(e.borrow));
                    chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                    chk("zero", 64'(bus.zero), 64'(e.zero));
                    chk("neg", 64'(bus.neg), 64'(e.neg));
                    chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                        void'(sb.pop_front());
                        last_diff = e.diff;
                        last_hs   = cyc + 1;
                        post_hs   = 1'b1;
                    end
                end
                was_valid = 1'b1;
            end else begin
                was_valid = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        int          acc;
        logic [63:0] ra, rb;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_diff", bus.diff, 64'd0);
        chk("reset_flags", 64'({bus.borrow, bus.ovf, bus.zero, bus.neg}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);

        send(64'd10, 64'd3, 0, 1'b1, acc);
        send(64'd0, 64'd1, 0, 1'b1, acc);
        send(64'h8000_0000_0000_0000, 64'd1, 0, 1'b1, acc);
        send(64'h0000_0001_0000_0000, 64'd1, 0, 1'b1, acc);
        send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 3, 1'b1, acc);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, acc);
        chk("back_to_back_accept", 64'(acc), 64'(last_hs + 1));

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = {$urandom, $urandom};
                1: rb = ra ^ 64'($urandom_range(0, 3));
                2: rb = ra + (64'd1 << (16 * $urandom_range(0, 3)));
                default: rb = {ra[63], 63'($urandom)};
            endcase
            send(ra, rb, $urandom_range(0, 2), 1'b1, acc);
        end
        drain();

        // Abort in the second CALC cycle
        send(64'd500, 64'd7, 0, 1'b0, acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
        chk("abort_diff", bus.diff, 64'd0);
        chk("abort_flags", 64'({bus.borrow, bus.ovf, bus.zero, bus.neg}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_release_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 1), 1'b1, acc);
        end
        drain();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
